// File: rtl/cnn_pkg.sv
// Shared fixed-point constants, FSM encoding and helpers for the CNN back-end stages.
package cnn_pkg;
  localparam int DATA_W = 16;
  localparam int FRAC   = 8;

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, EMIT, DONE} fc_state_t;

  // Q16.16 products plus log2(N) bits of headroom never overflow
  function automatic int acc_w(input int n);
    return 32 + $clog2(n);
  endfunction

  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [63:0] v);
    if (v > 64'sd32767)       return 16'sh7FFF;
    else if (v < -64'sd32768) return 16'sh8000;
    else                      return v[DATA_W-1:0];
  endfunction
endpackage

// File: rtl/fc_mac.sv
// Dot-product accumulator: Q16.16 MAC, bias add, rescale to Q8.8, saturate, optional ReLU.
module fc_mac import cnn_pkg::*; #(
  parameter int AW        = 40,
  parameter int FRAC_BITS = FRAC,
  parameter bit RELU      = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     mac_en,
  input  logic                     bias_en,
  input  logic signed [DATA_W-1:0] feat,
  input  logic signed [DATA_W-1:0] weight,
  output logic signed [DATA_W-1:0] result
);
  logic signed [2*DATA_W-1:0] prod;
  logic signed [AW-1:0]       acc, total, scaled;
  logic signed [DATA_W-1:0]   sat;

  // On the bias cycle the weight port carries the Q8.8 bias; align it to Q16.16
  always_comb begin
    prod   = feat * weight;
    total  = acc + (AW'(weight) <<< FRAC_BITS);
    scaled = total >>> FRAC_BITS;
    sat    = sat16(64'(scaled));
    if (RELU && sat[DATA_W-1]) sat = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      result <= '0;
    end else begin
      if (clr)         acc <= '0;
      else if (mac_en) acc <= acc + AW'(prod);
      if (bias_en)     result <= sat;
    end
  end
endmodule

// File: rtl/fc_layer.sv
// Dense layer: buffers the pooled feature stream, then streams one Q8.8 score per neuron
// using weights fetched from an external synchronous memory (row j = weights then bias).
module fc_layer import cnn_pkg::*; #(
  parameter int NUM_INPUTS                  = 28830,
  parameter int NUM_OUTPUTS                 = 10,
  parameter int FIXED_POINT_FRACTIONAL_BITS = FRAC,
  parameter bit RELU                        = 1'b1,
  localparam int IN_AW = $clog2(NUM_INPUTS + 1),
  localparam int WAW   = $clog2(NUM_OUTPUTS * (NUM_INPUTS + 1)),
  localparam int OW    = $clog2(NUM_OUTPUTS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] input_data,
  input  logic [IN_AW-1:0]  input_addr,
  input  logic              input_valid,
  input  logic              input_done,
  output logic [WAW-1:0]    weight_addr,
  input  logic [DATA_W-1:0] weight_data,
  output logic [DATA_W-1:0] output_data,
  output logic [OW-1:0]     output_addr,
  output logic              output_valid,
  output logic              busy,
  output logic              fc_done
);
  localparam int BW = $clog2(NUM_INPUTS);
  localparam int TW = $clog2(NUM_INPUTS + 2);
  localparam int AW = acc_w(NUM_INPUTS);
  localparam logic [TW-1:0]    T_N    = TW'(NUM_INPUTS);
  localparam logic [TW-1:0]    T_BIAS = TW'(NUM_INPUTS + 1);
  localparam logic [IN_AW-1:0] A_N    = IN_AW'(NUM_INPUTS);
  localparam logic [OW-1:0]    J_LAST = OW'(NUM_OUTPUTS - 1);

  fc_state_t         state;
  logic [TW-1:0]     t;
  logic [OW-1:0]     j;
  logic [DATA_W-1:0] buffer [NUM_INPUTS];
  logic [DATA_W-1:0] buf_q;
  logic              mac_en, bias_en, clr;

  // weight_data and buf_q both lag the address by one cycle, so t=1..N carry products
  assign mac_en  = (state == COMPUTE) && (t != '0) && (t <= T_N);
  assign bias_en = (state == COMPUTE) && (t == T_BIAS);
  assign clr     = (state == EMIT);

  always_ff @(posedge clk) begin
    if (state == LOAD && input_valid && input_addr < A_N)
      buffer[input_addr[BW-1:0]] <= input_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      t            <= '0;
      j            <= '0;
      weight_addr  <= '0;
      output_addr  <= '0;
      output_valid <= 1'b0;
      busy         <= 1'b0;
      fc_done      <= 1'b0;
      buf_q        <= '0;
    end else begin
      output_valid <= 1'b0;
      fc_done      <= 1'b0;
      if (state == COMPUTE && t < T_N) buf_q <= buffer[t[BW-1:0]];
      case (state)
        IDLE: if (enable) begin
          state <= LOAD;
          busy  <= 1'b1;
        end
        LOAD: if (input_done) begin
          state       <= COMPUTE;
          t           <= '0;
          j           <= '0;
          weight_addr <= '0;
        end
        COMPUTE: begin
          t <= t + TW'(1);
          if (t < T_N) weight_addr <= weight_addr + WAW'(1);
          if (t == T_BIAS) begin
            state        <= EMIT;
            t            <= '0;
            output_valid <= 1'b1;
            output_addr  <= j;
          end
        end
        EMIT: begin
          if (j == J_LAST) begin
            state   <= DONE;
            fc_done <= 1'b1;
          end else begin
            // bias slot of row j is immediately followed by row j+1's base
            state       <= COMPUTE;
            j           <= j + OW'(1);
            weight_addr <= weight_addr + WAW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  fc_mac #(.AW(AW), .FRAC_BITS(FIXED_POINT_FRACTIONAL_BITS), .RELU(RELU)) u_mac (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .mac_en  (mac_en),
    .bias_en (bias_en),
    .feat    (buf_q),
    .weight  (weight_data),
    .result  (output_data)
  );
endmodule

// File: tb/tb_fc_layer.sv
// Bench for fc_layer at 4 inputs / 2 outputs, with ReLU and non-ReLU instances in lockstep.
module tb_fc_layer;
  logic        clk = 1'b0;
  logic        reset, enable, input_valid, input_done;
  logic [15:0] input_data;
  logic [2:0]  input_addr;
  logic [3:0]  wa1, wa0;
  logic [15:0] wd1, wd0, od1, od0;
  logic        oa1, oa0, ov1, ov0, busy1, busy0, fd1, fd0;

  logic [15:0] feat [4];
  logic [15:0] mem  [16];
  logic [16:0] q1 [$];
  logic [16:0] q0 [$];
  int          ovc [$];
  int cyc = 0, dn = 0, wa5_cyc = -1, done_cyc = -1, idle_cyc = -1;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    wd1 <= mem[wa1];
    wd0 <= mem[wa0];
  end

  fc_layer #(.NUM_INPUTS(4), .NUM_OUTPUTS(2), .FIXED_POINT_FRACTIONAL_BITS(8), .RELU(1'b1)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .input_data(input_data), .input_addr(input_addr),
    .input_valid(input_valid), .input_done(input_done), .weight_addr(wa1), .weight_data(wd1),
    .output_data(od1), .output_addr(oa1), .output_valid(ov1), .busy(busy1), .fc_done(fd1));

  fc_layer #(.NUM_INPUTS(4), .NUM_OUTPUTS(2), .FIXED_POINT_FRACTIONAL_BITS(8), .RELU(1'b0)) u0 (
    .clk(clk), .reset(reset), .enable(enable), .input_data(input_data), .input_addr(input_addr),
    .input_valid(input_valid), .input_done(input_done), .weight_addr(wa0), .weight_data(wd0),
    .output_data(od0), .output_addr(oa0), .output_valid(ov0), .busy(busy0), .fc_done(fd0));

  always @(negedge clk) begin
    if (ov1) begin q1.push_back({oa1, od1}); ovc.push_back(cyc); end
    if (ov0) q0.push_back({oa0, od0});
    if (wa1 == 4'd5 && wa5_cyc < 0) wa5_cyc = cyc;
    if (fd1) begin dn++; done_cyc = cyc; end
    if (done_cyc >= 0 && !busy1 && idle_cyc < 0) idle_cyc = cyc;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Dot product in plain integer arithmetic, bias scaled to Q16.16, floor to Q8.8
  function automatic logic [15:0] model(input int jj, input bit relu);
    longint s = 0;
    logic [15:0] r;
    for (int i = 0; i < 4; i++)
      s += longint'($signed(feat[i])) * longint'($signed(mem[jj*5 + i]));
    s += longint'($signed(mem[jj*5 + 4])) * 256;
    s = s >>> 8;
    if (s > 32767)       r = 16'h7FFF;
    else if (s < -32768) r = 16'h8000;
    else                 r = 16'(s);
    if (relu && r[15]) r = 16'h0000;
    return r;
  endfunction

  task automatic do_run(input string tag, input bit done_last, input bit bad_addr,
                        input bit skip3, input bit noise, input bit abort);
    int c, base0;
    q1.delete(); q0.delete(); ovc.delete();
    dn = 0; wa5_cyc = -1; done_cyc = -1; idle_cyc = -1;
    enable = 1'b1; step(); enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (skip3 && i == 3) continue;
      input_valid = 1'b1; input_addr = 3'(i); input_data = feat[i];
      if (done_last && i == 3) input_done = 1'b1;
      step();
    end
    input_valid = 1'b0;
    if (bad_addr) begin
      input_valid = 1'b1; input_addr = 3'd7; input_data = 16'h1234; step();
      input_valid = 1'b0;
    end
    if (!done_last) begin input_done = 1'b1; step(); end
    input_done = 1'b0;
    base0 = cyc;
    if (abort) begin
      for (c = 0; c < 100 && wa1 != 4'd7; c++) step();
      chk({tag, " reach j1 t2"}, wa1, 7);
      #2 reset = 1'b0;
      #1;
      chk({tag, " rst weight_addr"}, wa1, 0);
      chk({tag, " rst output_data"}, od1, 0);
      chk({tag, " rst output_addr"}, oa1, 0);
      chk({tag, " rst output_valid"}, ov1, 0);
      chk({tag, " rst busy"}, busy1, 0);
      chk({tag, " rst fc_done"}, fd1, 0);
      step(); step();
      reset = 1'b1;
      step(); step();
      chk({tag, " no partial done"}, dn, 0);
      chk({tag, " idle after rst"}, busy1, 0);
      return;
    end
    if (noise) begin
      step(); step();
      enable = 1'b1; input_valid = 1'b1; input_addr = 3'd0; input_data = 16'h5A5A; input_done = 1'b1;
      step();
      enable = 1'b0; input_valid = 1'b0; input_done = 1'b0;
    end
    for (c = 0; c < 200 && dn == 0; c++) step();
    step(); step();
    chk({tag, " fc_done count"}, dn, 1);
    chk({tag, " relu count"}, q1.size(), 2);
    chk({tag, " lin count"}, q0.size(), 2);
    for (int jj = 0; jj < 2; jj++) begin
      chk($sformatf("%s relu n%0d", tag, jj), (q1.size() > jj) ? q1[jj] : 17'h1FFFF, {1'(jj), model(jj, 1'b1)});
      chk($sformatf("%s lin n%0d", tag, jj), (q0.size() > jj) ? q0[jj] : 17'h1FFFF, {1'(jj), model(jj, 1'b0)});
    end
    chk({tag, " valid0 lat"}, (ovc.size() > 0) ? ovc[0] : -1, base0 + 6);
    chk({tag, " row1 base"}, wa5_cyc, base0 + 7);
    chk({tag, " valid1 lat"}, (ovc.size() > 1) ? ovc[1] : -1, wa5_cyc + 6);
    chk({tag, " done lat"}, done_cyc, ((ovc.size() > 1) ? ovc[1] : -1) + 1);
    chk({tag, " busy fall"}, idle_cyc, done_cyc + 1);
  endtask

  task automatic set_s1();
    feat[0] = 16'h0100; feat[1] = 16'h0200; feat[2] = 16'hFF00; feat[3] = 16'h0080;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 4; i++) mem[i] = 16'h0100;
    mem[5] = 16'h0080; mem[6] = 16'hFF00; mem[7] = 16'h0000; mem[8] = 16'h0200; mem[9] = 16'h0040;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; input_valid = 1'b0; input_done = 1'b0;
    input_data = '0; input_addr = '0;
    set_s1();
    repeat (3) @(posedge clk);
    #1;
    chk("reset weight_addr", wa1, 0);
    chk("reset output_data", od1, 0);
    chk("reset output_addr", oa1, 0);
    chk("reset output_valid", ov1, 0);
    chk("reset busy", busy1, 0);
    chk("reset fc_done", fd1, 0);
    reset = 1'b1; step();

    input_done = 1'b1; step(); input_done = 1'b0; step(); step();
    chk("idle input_done busy", busy1, 0);
    chk("idle input_done no done", dn, 0);

    do_run("s1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      feat[i] = 16'h7F00; mem[i] = 16'h7F00; mem[5+i] = 16'h8100;
    end
    mem[4] = 16'h0000; mem[9] = 16'h0000;
    do_run("s2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    set_s1();
    do_run("s4abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_run("s4redo", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    input_valid = 1'b1; input_addr = 3'd3; input_data = 16'h7777; step();
    input_valid = 1'b0;
    do_run("s5", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

    do_run("s6", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) feat[i] = r[0] ? 16'($urandom) : 16'($urandom_range(0, 1023)) - 16'd512;
      for (int i = 0; i < 10; i++) mem[i] = r[0] ? 16'($urandom) : 16'($urandom_range(0, 1023)) - 16'd512;
      do_run($sformatf("rnd%0d", r), 1'(r >> 1), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
